// File: rtl/counter_mod_ud.sv
// Modulo-MOD up/down counter with an enable prescaler, synchronous clear/load
// and a registered tick that pulses on the cycle the count wraps.
module counter_mod_ud #(
  parameter int BITS     = 4,
  parameter int MOD      = 10,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            clear,
  input  logic            load,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] q,
  output logic            tick,
  output logic            at_term
);

  localparam int PBITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [BITS-1:0]  QMAX = BITS'(MOD - 1);
  localparam logic [PBITS-1:0] PMAX = PBITS'(PRESCALE - 1);

  if (MOD < 2 || MOD > 2 ** BITS || PRESCALE < 1) begin : g_bad_params
    $error("counter_mod_ud: illegal parameters BITS=%0d MOD=%0d PRESCALE=%0d",
           BITS, MOD, PRESCALE);
  end

  logic [PBITS-1:0] pcnt;

  // Out-of-range load values clamp to the top of the count range.
  function automatic logic [BITS-1:0] sat_load(input logic [BITS-1:0] v);
    return (v > QMAX) ? QMAX : v;
  endfunction

  // The terminal compare is taken before the add/subtract so q never leaves 0..MOD-1.
  function automatic logic [BITS-1:0] step_q(input logic [BITS-1:0] cur, input logic dir);
    if (dir) return (cur == QMAX) ? '0 : cur + BITS'(1);
    else     return (cur == '0) ? QMAX : cur - BITS'(1);
  endfunction

  assign at_term = up ? (q == QMAX) : (q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      pcnt <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      pcnt <= '0;
      tick <= 1'b0;
    end else if (load) begin
      q    <= sat_load(din);
      pcnt <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pcnt == PMAX) begin
        pcnt <= '0;
        q    <= step_q(q, up);
        tick <= at_term;
      end else begin
        pcnt <= pcnt + PBITS'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_mod_ud.sv
// Directed bench for counter_mod_ud: vector table on the default instance plus
// hand-written async-reset and prescale sequences (second instance, PRESCALE=3).
module tb_counter_mod_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en, up, clear, load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tick, at_term;

  logic       en2, up2, clear2, load2;
  logic [3:0] din2;
  logic [3:0] q2;
  logic       tick2, at_term2;

  int n_checks = 0;
  int n_fail   = 0;

  counter_mod_ud #(.BITS(4), .MOD(10), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .din(din), .q(q), .tick(tick), .at_term(at_term)
  );

  counter_mod_ud #(.BITS(4), .MOD(10), .PRESCALE(3)) dut_ps (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .clear(clear2), .load(load2),
    .din(din2), .q(q2), .tick(tick2), .at_term(at_term2)
  );

  typedef struct {
    logic       clear;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] din;
    logic [3:0] q;
    logic       tick;
    logic       at;
  } vec_t;

  vec_t tv[$];

  task automatic addv(input logic c, input logic l, input logic e, input logic u,
                      input logic [3:0] d, input logic [3:0] eq, input logic et,
                      input logic ea);
    vec_t v;
    v.clear = c; v.load = l; v.en = e; v.up = u; v.din = d;
    v.q = eq; v.tick = et; v.at = ea;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive1(input logic c, input logic l, input logic e, input logic u,
                        input logic [3:0] d);
    clear = c; load = l; en = e; up = u; din = d;
  endtask

  // One clock on the prescaled instance, then check its count and tick.
  task automatic step2(input logic e, input logic [3:0] eq, input string name);
    en2 = e;
    @(posedge clk); #1;
    chk({name, " q"}, q2, eq);
    chk({name, " tick"}, tick2, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive1(0, 0, 0, 1, 4'd0);
    en2 = 0; up2 = 1; clear2 = 0; load2 = 0; din2 = 4'd0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset q", q, 0);
    chk("reset tick", tick, 0);
    chk("reset at_term up", at_term, 0);
    up = 0; #1;
    chk("reset at_term down", at_term, 1);
    chk("reset q2", q2, 0);
    @(negedge clk);
    rst = 1'b1;

    // Up wrap: 1..9, 0 (tick), 1
    for (int i = 1; i <= 9; i++) addv(0, 0, 1, 1, 4'd0, 4'(i), 0, (i == 9));
    addv(0, 0, 1, 1, 4'd0, 4'd0, 1, 0);
    addv(0, 0, 1, 1, 4'd0, 4'd1, 0, 0);
    // Down wrap from a load of 2: 2,1,0,9 (tick),8
    addv(0, 1, 1, 0, 4'd2, 4'd2, 0, 0);
    addv(0, 0, 1, 0, 4'd0, 4'd1, 0, 0);
    addv(0, 0, 1, 0, 4'd0, 4'd0, 0, 1);
    addv(0, 0, 1, 0, 4'd0, 4'd9, 1, 0);
    addv(0, 0, 1, 0, 4'd0, 4'd8, 0, 0);
    // Load saturation, load with en=0, clear beats load, hold
    addv(0, 1, 0, 1, 4'd12, 4'd9, 0, 1);
    addv(0, 1, 0, 1, 4'd7,  4'd7, 0, 0);
    addv(0, 1, 0, 1, 4'd10, 4'd9, 0, 1);
    addv(0, 1, 0, 1, 4'd9,  4'd9, 0, 1);
    addv(1, 1, 1, 0, 4'd3,  4'd0, 0, 1);
    addv(0, 0, 0, 0, 4'd5,  4'd0, 0, 1);
    // Reversal: up to 9, down to 8 (no tick), up to 9, wrap to 0 with tick
    for (int i = 1; i <= 9; i++) addv(0, 0, 1, 1, 4'd0, 4'(i), 0, (i == 9));
    addv(0, 0, 1, 0, 4'd0, 4'd8, 0, 0);
    addv(0, 0, 1, 1, 4'd0, 4'd9, 0, 1);
    addv(0, 0, 1, 1, 4'd0, 4'd0, 1, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive1(tv[i].clear, tv[i].load, tv[i].en, tv[i].up, tv[i].din);
      @(posedge clk); #1;
      chk($sformatf("vec%0d q", i), q, tv[i].q);
      chk($sformatf("vec%0d tick", i), tick, tv[i].tick);
      chk($sformatf("vec%0d at_term", i), at_term, tv[i].at);
    end

    // Async reset while tick is high, checked before the next edge
    #2 rst = 1'b0;
    #1;
    chk("async rst tick", tick, 0);
    chk("async rst q", q, 0);
    drive1(0, 0, 1, 1, 4'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("post-release q", q, 1);
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("count q=%0d", i), q, i);
    end
    #2 rst = 1'b0;
    #1;
    chk("async rst mid q", q, 0);
    chk("async rst mid tick", tick, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release first step q", q, 1);
    drive1(0, 0, 0, 1, 4'd0);

    // Prescale by 3, with an enable gap mid-prescale
    clear2 = 1; step2(0, 4'd0, "ps clear"); clear2 = 0;
    step2(1, 4'd0, "ps e1");
    step2(1, 4'd0, "ps e2");
    step2(1, 4'd1, "ps e3");
    step2(1, 4'd1, "ps e4");
    step2(1, 4'd1, "ps e5");
    step2(1, 4'd2, "ps e6");
    step2(1, 4'd2, "ps e7");
    step2(0, 4'd2, "ps gap1");
    step2(0, 4'd2, "ps gap2");
    step2(1, 4'd2, "ps e8");
    step2(1, 4'd3, "ps e9");
    step2(1, 4'd3, "ps e10");
    // Reset mid-prescale discards the phase
    #2 rst = 1'b0;
    #1;
    chk("ps rst q", q2, 0);
    rst = 1'b1;
    step2(1, 4'd0, "ps r1");
    step2(1, 4'd0, "ps r2");
    step2(1, 4'd1, "ps r3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
